// File: rtl/stack_cmd_decoder.sv
// stack_cmd_decoder
// -----------------------------------------------------------------------------
// Front end of the stack calculator. The four push-buttons are synchronized
// and debounced. The union of all buttons held during one press/release
// episode is collected as a chord. The chord is decoded into one stack opcode.
// That opcode is offered, together with the synchronized switch value, on a
// valid/ready interface to the stack core.
//
// Ports
//   CLK                      system clock, rising-edge
//   RESET_N                  asynchronous active-low reset
//   ButtonUp_unfiltered      raw button0
//   ButtonDown_unfiltered    raw button1
//   ButtonRight_unfiltered   raw button2
//   ButtonLeft_unfiltered    raw button3
//   SWITCH[7:0]              raw operand switches
//   cmd_ready                consumer accepts the pending command
//   cmd_valid                command pending
//   cmd_op[3:0]              decoded opcode (1..8, 0 never issued)
//   cmd_operand[7:0]         switch value latched at chord completion
//   cmd_chord[3:0]           chord {Left,Right,Down,Up} of the pending command
//   chord_err                one-cycle pulse for an unrecognized chord
//   btn_db[3:0]              debounced button levels {Left,Right,Down,Up}
// -----------------------------------------------------------------------------
module stack_cmd_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ButtonUp_unfiltered,
    input  logic       ButtonDown_unfiltered,
    input  logic       ButtonRight_unfiltered,
    input  logic       ButtonLeft_unfiltered,
    input  logic [7:0] SWITCH,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [3:0] cmd_op,
    output logic [7:0] cmd_operand,
    output logic [3:0] cmd_chord,
    output logic       chord_err,
    output logic [3:0] btn_db
);

    // Terminal count: a level change needs DEBOUNCE_CYCLES differing samples.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ISSUE
    } stateT;

    stateT            state;
    stateT            nextState;

    logic [3:0]       btnRaw;
    logic [3:0]       btnMeta;
    logic [3:0]       btnSync;
    logic [7:0]       swMeta;
    logic [7:0]       swSync;
    logic [CNT_W-1:0] dbCnt [4];

    logic [3:0]       chordAcc;
    logic [3:0]       decodedOp;
    logic             chordKnown;
    logic             chordDone;

    assign btnRaw = {ButtonLeft_unfiltered, ButtonRight_unfiltered,
                     ButtonDown_unfiltered, ButtonUp_unfiltered};

    // Two-flop synchronizers for the buttons and the switch bank. The switches
    // are only sampled once the chord is complete. By then they have long been
    // stable, so they get no debouncing.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            btnMeta <= '0;
            btnSync <= '0;
            swMeta  <= '0;
            swSync  <= '0;
        end else begin
            btnMeta <= btnRaw;
            btnSync <= btnMeta;
            swMeta  <= SWITCH;
            swSync  <= swMeta;
        end
    end

    // Per-button debouncer. Any sample that agrees with the current debounced
    // level restarts the count. The level flips only after an unbroken run of
    // DEBOUNCE_CYCLES disagreeing samples, so shorter glitches are ignored.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_db <= '0;
            for (int i = 0; i < 4; i++) begin
                dbCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btnSync[i] == btn_db[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DB_LAST) begin
                    btn_db[i] <= ~btn_db[i];
                    dbCnt[i]  <= '0;
                end else begin
                    dbCnt[i] <= dbCnt[i] + 1'b1;
                end
            end
        end
    end

    // Chord-to-opcode table. A result of zero means the chord is not a command.
    function automatic logic [3:0] decodeChord(input logic [3:0] chord);
        case (chord)
            4'b0001: return 4'd1;
            4'b0010: return 4'd2;
            4'b0101: return 4'd3;
            4'b0110: return 4'd4;
            4'b1010: return 4'd5;
            4'b1001: return 4'd6;
            4'b1101: return 4'd7;
            4'b1110: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // The chord is complete when all buttons are released. At that point
    // btn_db adds nothing, so the accumulator alone is the chord.
    assign decodedOp  = decodeChord(chordAcc);
    assign chordKnown = (decodedOp != 4'd0);
    assign chordDone  = (state == COLLECT) && (btn_db == 4'b0000);

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. ISSUE never looks at the buttons. An episode that
    // starts during a stall is picked up only if it is still held when IDLE is
    // reached.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (btn_db != 4'b0000) begin
                    nextState = COLLECT;
                end
            end
            COLLECT: begin
                if (btn_db == 4'b0000) begin
                    nextState = chordKnown ? ISSUE : IDLE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Output logic. A command is pending exactly while in ISSUE. Reset
    // therefore drops cmd_valid at once.
    always_comb begin
        cmd_valid = (state == ISSUE);
    end

    // Chord accumulation and command capture. Staggered presses are ORed in
    // while any button is still down. The command fields are written only at
    // chord completion, so they stay stable for the whole ISSUE stall.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            chordAcc    <= '0;
            cmd_op      <= '0;
            cmd_operand <= '0;
            cmd_chord   <= '0;
            chord_err   <= 1'b0;
        end else begin
            chord_err <= chordDone && !chordKnown;
            case (state)
                IDLE:    chordAcc <= btn_db;
                COLLECT: chordAcc <= chordDone ? 4'b0000 : (chordAcc | btn_db);
                default: chordAcc <= 4'b0000;
            endcase
            if (chordDone && chordKnown) begin
                cmd_op      <= decodedOp;
                cmd_operand <= swSync;
                cmd_chord   <= chordAcc;
            end
        end
    end

endmodule

// File: tb/tb_stack_cmd_decoder.sv
// tb_stack_cmd_decoder
// -----------------------------------------------------------------------------
// Directed bench for stack_cmd_decoder with DEBOUNCE_CYCLES = 16.
// Inputs change just after a falling edge. Outputs are sampled at the falling
// edge, away from the rising edge where the DUT updates.
// A raw edge reaches btn_db after 2 + 16 = 18 rising edges. cmd_valid rises
// one rising edge after that when the buttons are released.
// -----------------------------------------------------------------------------
module tb_stack_cmd_decoder;

    logic       clock;
    logic       resetN;
    logic       btnUp;
    logic       btnDown;
    logic       btnRight;
    logic       btnLeft;
    logic [7:0] switchBank;
    logic       cmdReady;
    logic       cmdValid;
    logic [3:0] cmdOp;
    logic [7:0] cmdOperand;
    logic [3:0] cmdChord;
    logic       chordErr;
    logic [3:0] btnDb;

    int checkCount    = 0;
    int passCount     = 0;
    int failCount     = 0;
    int transferCount = 0;
    int errCycles     = 0;

    stack_cmd_decoder #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W          (20)
    ) dut (
        .CLK                   (clock),
        .RESET_N               (resetN),
        .ButtonUp_unfiltered   (btnUp),
        .ButtonDown_unfiltered (btnDown),
        .ButtonRight_unfiltered(btnRight),
        .ButtonLeft_unfiltered (btnLeft),
        .SWITCH                (switchBank),
        .cmd_ready             (cmdReady),
        .cmd_valid             (cmdValid),
        .cmd_op                (cmdOp),
        .cmd_operand           (cmdOperand),
        .cmd_chord             (cmdChord),
        .chord_err             (chordErr),
        .btn_db                (btnDb)
    );

    // 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count handshake transfers and chord_err high cycles as the DUT sees them
    // at each rising edge.
    always @(posedge clock) begin
        if (resetN && cmdValid && cmdReady) transferCount++;
        if (resetN && chordErr) errCycles++;
    end

    // Drive buttons {Left,Right,Down,Up} and switches, then let the given
    // number of clock cycles pass. The task returns just after a falling edge.
    task automatic applyStimulus(input logic [3:0] buttons, input logic [7:0] sw,
                                 input int cycles);
        {btnLeft, btnRight, btnDown, btnUp} = buttons;
        switchBank = sw;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Accept the pending command in one cycle. cmd_valid must be low afterwards.
    task automatic acceptCommand(input string tag);
        cmdReady = 1'b1;
        @(negedge clock);
        checkOutput({tag, "_valid_after_xfer"}, 32'(cmdValid), 32'd0);
        cmdReady = 1'b0;
    endtask

    // Full episode: hold the chord for 30 cycles, then release it. The command
    // must appear exactly 19 cycles after release and must be accepted once.
    task automatic runChord(input string tag, input logic [3:0] buttons,
                            input logic [7:0] sw, input logic [3:0] expOp);
        int xferStart;
        xferStart = transferCount;
        cmdReady  = 1'b0;
        applyStimulus(buttons, sw, 30);
        applyStimulus(4'b0000, sw, 18);
        checkOutput({tag, "_valid_early"}, 32'(cmdValid), 32'd0);
        applyStimulus(4'b0000, sw, 1);
        checkOutput({tag, "_valid"},   32'(cmdValid),   32'd1);
        checkOutput({tag, "_op"},      32'(cmdOp),      32'(expOp));
        checkOutput({tag, "_chord"},   32'(cmdChord),   32'(buttons));
        checkOutput({tag, "_operand"}, 32'(cmdOperand), 32'(sw));
        acceptCommand(tag);
        applyStimulus(4'b0000, sw, 5);
        checkOutput({tag, "_xfers"}, 32'(transferCount - xferStart), 32'd1);
    endtask

    initial begin
        int xferStart;
        int errStart;

        resetN     = 1'b0;
        cmdReady   = 1'b0;
        btnUp      = 1'b0;
        btnDown    = 1'b0;
        btnRight   = 1'b0;
        btnLeft    = 1'b0;
        switchBank = 8'h00;
        repeat (3) @(negedge clock);

        // Reset state.
        checkOutput("rst_valid",   32'(cmdValid),   32'd0);
        checkOutput("rst_op",      32'(cmdOp),      32'd0);
        checkOutput("rst_operand", 32'(cmdOperand), 32'd0);
        checkOutput("rst_chord",   32'(cmdChord),   32'd0);
        checkOutput("rst_err",     32'(chordErr),   32'd0);
        checkOutput("rst_btn_db",  32'(btnDb),      32'd0);
        resetN = 1'b1;
        applyStimulus(4'b0000, 8'h00, 5);

        // PUSH with cmd_ready held high: exact press latency, release latency
        // and acceptance on the first valid cycle.
        xferStart = transferCount;
        cmdReady  = 1'b1;
        applyStimulus(4'b0001, 8'd69, 17);
        checkOutput("push_db_at_17", 32'(btnDb), 32'd0);
        applyStimulus(4'b0001, 8'd69, 1);
        checkOutput("push_db_at_18", 32'(btnDb), 32'd1);
        applyStimulus(4'b0001, 8'd69, 82);
        checkOutput("push_valid_while_held", 32'(cmdValid), 32'd0);
        applyStimulus(4'b0000, 8'd69, 18);
        checkOutput("push_db_released", 32'(btnDb),    32'd0);
        checkOutput("push_valid_early", 32'(cmdValid), 32'd0);
        applyStimulus(4'b0000, 8'd69, 1);
        checkOutput("push_valid",   32'(cmdValid),   32'd1);
        checkOutput("push_op",      32'(cmdOp),      32'd1);
        checkOutput("push_operand", 32'(cmdOperand), 32'd69);
        checkOutput("push_chord",   32'(cmdChord),   32'b0001);
        applyStimulus(4'b0000, 8'd69, 1);
        checkOutput("push_valid_after", 32'(cmdValid), 32'd0);
        applyStimulus(4'b0000, 8'd69, 20);
        checkOutput("push_xfers", 32'(transferCount - xferStart), 32'd1);
        cmdReady = 1'b0;

        // Backpressure: the command holds through a long stall. A switch change
        // and a whole second Up episode during the stall must not disturb it.
        xferStart = transferCount;
        applyStimulus(4'b0001, 8'd42, 30);
        applyStimulus(4'b0000, 8'd42, 19);
        checkOutput("bp_valid",   32'(cmdValid),   32'd1);
        checkOutput("bp_operand", 32'(cmdOperand), 32'd42);
        applyStimulus(4'b0000, 8'd7, 10);
        checkOutput("bp_operand_hold", 32'(cmdOperand), 32'd42);
        applyStimulus(4'b0001, 8'd7, 30);
        applyStimulus(4'b0000, 8'd7, 25);
        checkOutput("bp_valid_stall", 32'(cmdValid),   32'd1);
        checkOutput("bp_op_stall",    32'(cmdOp),      32'd1);
        checkOutput("bp_chord_stall", 32'(cmdChord),   32'b0001);
        checkOutput("bp_opnd_stall",  32'(cmdOperand), 32'd42);
        acceptCommand("bp");
        applyStimulus(4'b0000, 8'd7, 30);
        checkOutput("bp_no_replay", 32'(cmdValid), 32'd0);
        checkOutput("bp_xfers", 32'(transferCount - xferStart), 32'd1);

        // Recognized chords.
        runChord("add",     4'b0101, 8'h11, 4'd3);
        runChord("sub",     4'b0110, 8'h22, 4'd4);
        runChord("inc",     4'b1101, 8'h33, 4'd7);
        runChord("dec",     4'b1110, 8'h44, 4'd8);
        runChord("pop",     4'b0010, 8'h55, 4'd2);
        runChord("clear",   4'b1010, 8'h66, 4'd5);
        runChord("rstaddr", 4'b1001, 8'hFF, 4'd6);

        // Staggered press: Left joins 10 cycles after Right+Up.
        applyStimulus(4'b0101, 8'h3C, 10);
        applyStimulus(4'b1101, 8'h3C, 30);
        applyStimulus(4'b0000, 8'h3C, 19);
        checkOutput("stagger_valid", 32'(cmdValid), 32'd1);
        checkOutput("stagger_op",    32'(cmdOp),    32'd7);
        checkOutput("stagger_chord", 32'(cmdChord), 32'b1101);
        acceptCommand("stagger");

        // Partial release: Left lets go first, and Right+Up still held keeps
        // the episode open.
        applyStimulus(4'b1101, 8'h3D, 30);
        applyStimulus(4'b0101, 8'h3D, 30);
        checkOutput("partial_db",    32'(btnDb),    32'b0101);
        checkOutput("partial_valid", 32'(cmdValid), 32'd0);
        applyStimulus(4'b0000, 8'h3D, 19);
        checkOutput("partial_valid_end", 32'(cmdValid), 32'd1);
        checkOutput("partial_op",        32'(cmdOp),    32'd7);
        acceptCommand("partial");

        // Bounce: Up toggles every 5 cycles, so the debounced level never moves.
        xferStart = transferCount;
        errStart  = errCycles;
        for (int seg = 0; seg < 12; seg++) begin
            applyStimulus((seg % 2 == 0) ? 4'b0001 : 4'b0000, 8'h01, 5);
            checkOutput("bounce_db", 32'(btnDb), 32'd0);
        end
        applyStimulus(4'b0000, 8'h01, 40);
        checkOutput("bounce_valid", 32'(cmdValid), 32'd0);
        checkOutput("bounce_xfers", 32'(transferCount - xferStart), 32'd0);
        checkOutput("bounce_err",   32'(errCycles - errStart),      32'd0);

        // Unrecognized chord Up+Down: one-cycle chord_err, no command.
        errStart = errCycles;
        applyStimulus(4'b0011, 8'h09, 30);
        applyStimulus(4'b0000, 8'h09, 18);
        checkOutput("err_before", 32'(chordErr), 32'd0);
        applyStimulus(4'b0000, 8'h09, 1);
        checkOutput("err_pulse", 32'(chordErr), 32'd1);
        checkOutput("err_valid", 32'(cmdValid), 32'd0);
        applyStimulus(4'b0000, 8'h09, 1);
        checkOutput("err_pulse_end", 32'(chordErr), 32'd0);
        applyStimulus(4'b0000, 8'h09, 10);
        checkOutput("err_cycles", 32'(errCycles - errStart), 32'd1);
        checkOutput("err_valid_later", 32'(cmdValid), 32'd0);
        runChord("push_after_err", 4'b0001, 8'h05, 4'd1);

        // Asynchronous reset while a command is pending.
        applyStimulus(4'b0001, 8'h5A, 30);
        applyStimulus(4'b0000, 8'h5A, 19);
        checkOutput("rst2_valid_before", 32'(cmdValid), 32'd1);
        xferStart = transferCount;
        resetN = 1'b0;
        #1;
        checkOutput("rst2_valid",   32'(cmdValid),   32'd0);
        checkOutput("rst2_op",      32'(cmdOp),      32'd0);
        checkOutput("rst2_operand", 32'(cmdOperand), 32'd0);
        checkOutput("rst2_chord",   32'(cmdChord),   32'd0);
        checkOutput("rst2_err",     32'(chordErr),   32'd0);
        checkOutput("rst2_btn_db",  32'(btnDb),      32'd0);
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        applyStimulus(4'b0000, 8'h5A, 40);
        checkOutput("rst2_no_replay", 32'(cmdValid), 32'd0);
        checkOutput("rst2_xfers", 32'(transferCount - xferStart), 32'd0);
        runChord("push_after_rst", 4'b0001, 8'h99, 4'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
